// File: rtl/hilo_acc_reg.sv
// HI/LO special-register pair with direct writes, same-cycle read bypass and a
// two-stage multiply-accumulate path (MADD/MADDU/MSUB/MSUBU) with busy and flush.
module hilo_acc_reg #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_hi,
  input  logic [DATA_WIDTH-1:0] hi_data_in,
  input  logic                  we_lo,
  input  logic [DATA_WIDTH-1:0] lo_data_in,
  input  logic                  acc_valid,
  input  logic [1:0]            acc_op,
  input  logic [DATA_WIDTH-1:0] acc_a,
  input  logic [DATA_WIDTH-1:0] acc_b,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] hi_data_out,
  output logic [DATA_WIDTH-1:0] lo_data_out,
  output logic                  busy
);

  localparam int ACC_W = 2 * DATA_WIDTH;

  function automatic logic signed [ACC_W-1:0] extend(input logic [DATA_WIDTH-1:0] v,
                                                     input logic                  sgn);
    extend = {{DATA_WIDTH{sgn & v[DATA_WIDTH-1]}}, v};
  endfunction

  logic [DATA_WIDTH-1:0]    hi_q;
  logic [DATA_WIDTH-1:0]    lo_q;
  logic                     vld_p1;
  logic                     sub_p1;
  logic signed [ACC_W-1:0]  prod_p1;
  logic signed [ACC_W-1:0]  a_ext_p0;
  logic signed [ACC_W-1:0]  b_ext_p0;
  logic signed [ACC_W-1:0]  acc_p2;
  logic signed [ACC_W-1:0]  sum_p2;

  // Stage 1: extend operands by signedness and register the full-width product
  always_comb begin
    a_ext_p0 = extend(acc_a, ~acc_op[0]);
    b_ext_p0 = extend(acc_b, ~acc_op[0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= acc_valid & ~flush;
    end
  end

  // Operands are captured only for real requests, so idle inputs never reach the datapath
  always_ff @(posedge clk) begin
    if (acc_valid && !flush) begin
      prod_p1 <= a_ext_p0 * b_ext_p0;
      sub_p1  <= acc_op[1];
    end
  end

  // Stage 2: commit modulo 2^(2W); direct writes override their half afterwards
  always_comb begin
    acc_p2 = {hi_q, lo_q};
    sum_p2 = sub_p1 ? (acc_p2 - prod_p1) : (acc_p2 + prod_p1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= RESET_VALUE;
      lo_q <= RESET_VALUE;
    end else begin
      if (vld_p1 && !flush) begin
        hi_q <= sum_p2[ACC_W-1:DATA_WIDTH];
        lo_q <= sum_p2[DATA_WIDTH-1:0];
      end
      if (we_hi) hi_q <= hi_data_in;
      if (we_lo) lo_q <= lo_data_in;
    end
  end

  always_comb begin
    hi_data_out = we_hi ? hi_data_in : hi_q;
    lo_data_out = we_lo ? lo_data_in : lo_q;
    if (rst) begin
      hi_data_out = RESET_VALUE;
      lo_data_out = RESET_VALUE;
    end
  end

  assign busy = vld_p1;

endmodule

// File: tb/tb_hilo_acc_reg.sv
// Directed bench for hilo_acc_reg: expected values are queued as stimulus is
// driven and popped when the corresponding DUT output is sampled.
module tb_hilo_acc_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        we_hi, we_lo, acc_valid, flush;
  logic [31:0] hi_data_in, lo_data_in, acc_a, acc_b;
  logic [1:0]  acc_op;
  logic [31:0] hi_data_out, lo_data_out;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  hilo_acc_reg #(.DATA_WIDTH(32), .RESET_VALUE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .we_hi(we_hi), .hi_data_in(hi_data_in),
    .we_lo(we_lo), .lo_data_in(lo_data_in),
    .acc_valid(acc_valid), .acc_op(acc_op), .acc_a(acc_a), .acc_b(acc_b),
    .flush(flush),
    .hi_data_out(hi_data_out), .lo_data_out(lo_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
      end
    end
  endtask

  task automatic chk_out(input string tag, input logic [63:0] expv);
    #1;
    push(expv);
    chk(tag, {hi_data_out, lo_data_out});
  endtask

  task automatic chk_busy(input string tag, input logic expv);
    #1;
    push({63'd0, expv});
    chk(tag, {63'd0, busy});
  endtask

  task automatic load(input logic [31:0] h, input logic [31:0] l);
    we_hi = 1'b1; hi_data_in = h;
    we_lo = 1'b1; lo_data_in = l;
    tick();
    we_hi = 1'b0; we_lo = 1'b0;
  endtask

  task automatic acc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    acc_valid = 1'b1; acc_op = op; acc_a = a; acc_b = b;
  endtask

  initial begin
    rst = 1'b1;
    we_hi = 0; we_lo = 0; acc_valid = 0; flush = 0;
    hi_data_in = 0; lo_data_in = 0; acc_a = 0; acc_b = 0; acc_op = 0;
    tick(); tick();
    chk_out("reset_out", 64'h0);
    chk_busy("reset_busy", 1'b0);
    rst = 1'b0;

    // direct write with same-cycle bypass
    we_hi = 1'b1; hi_data_in = 32'h12345678;
    chk_out("bypass_hi", 64'h12345678_00000000);
    tick();
    we_hi = 1'b0;
    chk_out("hold_hi", 64'h12345678_00000000);

    // reset pulse between edges with a write held
    we_hi = 1'b1; hi_data_in = 32'h0000DEAD;
    rst = 1'b1;
    chk_out("rst_async_out", 64'h0);
    tick();
    chk_out("rst_held_write", 64'h0);
    rst = 1'b0; we_hi = 1'b0;
    chk_out("rst_release", 64'h0);

    // reset while an accumulate sits in stage 1
    acc(2'b00, 32'd7, 32'd9);
    tick();
    acc_valid = 1'b0;
    chk_busy("midop_busy", 1'b1);
    rst = 1'b1;
    chk_busy("midop_rst_busy", 1'b0);
    rst = 1'b0;
    tick();
    chk_out("midop_discard", 64'h0);

    // MADD signed: 5 + (-1 * 3)
    load(32'h0, 32'h5);
    acc(2'b00, 32'hFFFFFFFF, 32'd3);
    chk_busy("madd_busy_pre", 1'b0);
    tick();
    acc_valid = 1'b0;
    chk_busy("madd_busy", 1'b1);
    chk_out("madd_stale", 64'h00000000_00000005);
    tick();
    chk_busy("madd_busy_done", 1'b0);
    chk_out("madd_result", 64'h00000000_00000002);

    // MSUBU wrap-around: 0 - 2
    load(32'h0, 32'h0);
    acc(2'b11, 32'd2, 32'd1);
    tick();
    acc_valid = 1'b0;
    tick();
    chk_out("msubu_wrap", 64'hFFFFFFFF_FFFFFFFE);

    // three back-to-back MADDU of 2^16 * 2^16
    load(32'h0, 32'h0);
    acc(2'b01, 32'h00010000, 32'h00010000);
    tick();
    chk_busy("b2b_busy1", 1'b1);
    tick();
    chk_busy("b2b_busy2", 1'b1);
    chk_out("b2b_commit1", 64'h00000001_00000000);
    tick();
    acc_valid = 1'b0;
    chk_busy("b2b_busy3", 1'b1);
    chk_out("b2b_commit2", 64'h00000002_00000000);
    tick();
    chk_busy("b2b_idle", 1'b0);
    chk_out("b2b_commit3", 64'h00000003_00000000);

    // commit collides with a direct LO write
    acc(2'b01, 32'h00010000, 32'h00010000);
    tick();
    acc_valid = 1'b0;
    we_lo = 1'b1; lo_data_in = 32'hAA;
    chk_out("collide_bypass", 64'h00000003_000000AA);
    tick();
    we_lo = 1'b0;
    chk_out("collide_result", 64'h00000004_000000AA);

    // flush in the commit cycle
    acc(2'b10, 32'd1, 32'd1);
    tick();
    acc_valid = 1'b0;
    flush = 1'b1;
    chk_busy("flush_busy", 1'b1);
    tick();
    flush = 1'b0;
    chk_busy("flush_busy_drop", 1'b0);
    chk_out("flush_unchanged", 64'h00000004_000000AA);

    // flush together with a new request drops it
    acc(2'b00, 32'd100, 32'd100);
    flush = 1'b1;
    tick();
    acc_valid = 1'b0; flush = 1'b0;
    chk_busy("flush_req_busy", 1'b0);
    tick();
    chk_out("flush_req_drop", 64'h00000004_000000AA);

    // MSUB signed: subtract (-2 * 3)
    acc(2'b10, 32'hFFFFFFFE, 32'd3);
    tick();
    acc_valid = 1'b0;
    tick();
    chk_out("msub_signed", 64'h00000004_000000B0);

    // MADDU treats 0xFFFFFFFF as unsigned
    load(32'h0, 32'h0);
    acc(2'b01, 32'hFFFFFFFF, 32'd2);
    tick();
    acc_valid = 1'b0;
    tick();
    chk_out("maddu_unsigned", 64'h00000001_FFFFFFFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_acc_reg.md
Name: hilo_acc_reg

Overview:
- Parametrised HI/LO special-register pair for the EX/MEM stage of the MIPS pipeline.
- Supports direct writes, as MTHI/MTLO/MULT/DIV results do.
- Adds a two-stage multiply-accumulate path for MADD, MADDU, MSUB and MSUBU, with a busy interlock and flush.
- Read ports bypass same-cycle direct writes, so no negedge write is needed.

Parameters:
- DATA_WIDTH, 32, width of HI and of LO. The accumulator {HI,LO} is 2*DATA_WIDTH.
- RESET_VALUE, 0, value loaded into HI and LO on reset.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- we_hi  input  1  direct write enable for HI.
- hi_data_in  input  DATA_WIDTH  direct write data for HI.
- we_lo  input  1  direct write enable for LO.
- lo_data_in  input  DATA_WIDTH  direct write data for LO.
- acc_valid  input  1  accumulate request this cycle.
- acc_op  input  2  00 MADD (signed), 01 MADDU, 10 MSUB (signed), 11 MSUBU.
- acc_a  input  DATA_WIDTH  multiplicand.
- acc_b  input  DATA_WIDTH  multiplier.
- flush  input  1  cancel any accumulate held in stage 1.
- hi_data_out  output  DATA_WIDTH  HI read value.
- lo_data_out  output  DATA_WIDTH  LO read value.
- busy  output  1  an accumulate is pending commit; HI/LO outputs are stale.

Behaviour:
- Reset (asynchronous, rst=1):
  - hi_q and lo_q go to RESET_VALUE.
  - Stage-1 valid is cleared; busy=0.
  - While rst=1, hi_data_out and lo_data_out read RESET_VALUE, regardless of the write enables.
- Stage 1 (cycle N): if acc_valid=1 and flush=0, register:
  - P = acc_a*acc_b as a 2W-bit product. Signed ops sign-extend both operands; unsigned ops zero-extend.
  - a subtract flag (acc_op[1]).
  - s1_valid=1.
  - Otherwise s1_valid=0.
- Stage 2 (cycle N+1): if s1_valid=1 and flush=0:
  - {hi_q,lo_q} <= {hi_q,lo_q} + P, or − P when the subtract flag is set.
  - Arithmetic is modulo 2^(2W); no overflow flag and no saturation.
- busy = s1_valid, a registered output with no combinational path from the inputs.
- Back-to-back accumulates:
  - acc_valid may be high every cycle, giving throughput 1/cycle.
  - Stage 1 captures a new product while stage 2 commits the previous one.
  - Each commit uses the {hi_q,lo_q} value left by the previous commit.
- Direct writes: we_hi and we_lo update hi_q and lo_q at posedge.
  - If a stage-2 commit occurs in the same cycle, the commit sum is computed from the pre-edge hi_q/lo_q.
  - The direct write then overrides the half it targets; the other half takes the commit result.
- Flush:
  - flush=1 suppresses the stage-2 commit that cycle and clears s1_valid.
  - A flush in the same cycle as acc_valid also drops the new request.
  - Direct writes are not affected by flush.
- Read bypass:
  - hi_data_out = we_hi ? hi_data_in : hi_q, and likewise for LO.
  - There is no bypass of a pending accumulate. Consumers (MFHI/MFLO) must stall while busy=1.
- Reset mid-operation: an accumulate in stage 1 is discarded; HI/LO = RESET_VALUE on release.
- No X propagation: acc_a and acc_b are ignored when acc_valid=0.

Test Plan:
- Reset: rst pulse between edges → outputs 0 immediately; busy=0; we_hi=1 with data 0xDEAD held during rst → hi_data_out stays 0.
- Direct write + bypass: we_hi=1, hi_data_in=0x12345678 → hi_data_out=0x12345678 in the same cycle; register holds it after we_hi drops.
- MADD signed: HI/LO=0/5, acc_a=0xFFFFFFFF (−1), acc_b=3, op=00 → busy=1 for one cycle, then {HI,LO}=0x00000000_00000002.
- MSUBU with wrap-around: HI/LO=0/0, a=2, b=1, op=11 → {HI,LO}=0xFFFFFFFF_FFFFFFFE.
- Back-to-back: three MADDU of 0x10000×0x10000 on consecutive cycles from 0/0 → HI=3, LO=0 after the third commit; busy high for three cycles.
- Collision and flush:
  - Commit coincides with we_lo=1, lo_data_in=0xAA → LO=0xAA and HI=commit HI.
  - Separately, flush=1 in the commit cycle → HI/LO unchanged and busy drops the next cycle.
